aes_state_unloader: RTL and testbench
=====================================

// Module: aes_state_unloader
// PURPOSE
//  Reader side of the AES computed core state interface: accepts one 128-bit
//  result block per handshake and streams it out byte-serially, MSB byte first.
//  This is the FIPS-197 byte order, s[0] = data[127:120].
//  Sits between the core's result port and the narrow output pad/bus.
//  Holds the core off via in_ready. Supports zero-bubble back-to-back blocks.
// PARAMETERS
//  BLK_W   128  width of input block (multiple of OUT_W)
//  OUT_W   8    width of output beat
//  NBEATS  BLK_W/OUT_W (16)  derived, beats per block; not overridable
// PORTS
//  clk       in   1      single clock, all flops rising edge
//  rst       in   1      synchronous reset, active-high
//  in_valid  in   1      core presents a block
//  in_ready  out  1      unloader accepts block this cycle
//  in_data   in   BLK_W  block; sampled only on in_valid & in_ready
//  out_valid out  1      out_data/out_last valid
//  out_ready in   1      downstream accepts beat
//  out_data  out  OUT_W  current beat
//  out_last  out  1      high on final beat (beat NBEATS-1) of a block
//  busy      out  1      high while a block is held (state != IDLE)
// BEHAVIOUR
//  - Clock and reset: one clock. Reset is synchronous and active-high.
//  - Reset values:
//    - State IDLE, beat counter 0, shift register 0.
//    - out_valid=0, out_data=0, out_last=0, busy=0.
//    - in_ready is forced 0 while rst=1.
//  - States: IDLE, STREAM.
//    - IDLE: in_ready=1, out_valid=0.
//      On in_valid: load the shift register, cnt=0, go to STREAM.
//      out_valid rises the next cycle (1-cycle latency).
//    - STREAM: out_valid=1, out_data=sreg[BLK_W-1 -: OUT_W].
//      out_last = (cnt==NBEATS-1).
//      On out_valid & out_ready & !out_last: shift left by OUT_W, cnt++.
//      On the accepted last beat with in_valid=1: reload, cnt=0, stay in STREAM.
//      On the accepted last beat with in_valid=0: go to IDLE, out_valid=0.
//  - in_ready = IDLE | (STREAM & out_ready & out_last) when rst=0.
//    This is a combinational path from out_ready; it gives zero-bubble reload.
//  - Output stability: out_data and out_last do not change while
//    out_valid & !out_ready (AXI-style stall). out_valid never drops
//    without an accepted beat.
//  - Counter: $clog2(NBEATS) bits. It wraps only through an explicit reset
//    to 0 on load, never by overflow.
//  - Shift-in: zeros are shifted into the vacated low bits.
//  - Reset mid-block: the block is discarded. The next cycle is IDLE with
//    out_valid=0. No partial beat is re-emitted.
//  - in_valid while in_ready=0 is ignored. in_data is not sampled then.
// STRUCTURE
//  - Package ams_aes_pkg holds:
//    - AES_BLK_W=128 and AES_BYTE_W=8.
//    - typedef enum logic {ST_IDLE, ST_STREAM} unl_state_t.
//  - No sub-module. The shift register, counter and FSM are a single always
//    block plus ready/last assigns.
//  - Output flops map to the standard DFF cells. out_* fanout is buffered by
//    the existing drive-strength buffer wrappers at integration, not inside
//    this block.
// TESTING
//  1. Reset: hold rst 3 cycles with in_valid=1 -> in_ready=0, out_valid=0,
//     busy=0 throughout.
//  2. Single block 0x000102..0F, out_ready=1 -> out_data 00,01,..,0F on 16
//     consecutive cycles starting 1 cycle after accept; out_last only on 0F;
//     then IDLE.
//  3. Backpressure: drop out_ready on beats 3 and 4 for 5 cycles -> out_data
//     holds 03 and then 04 stable; no beat lost or duplicated; 16 beats total.
//  4. Back-to-back: blocks A=0xAA..AA and B=0xBB..BB, in_valid held ->
//     32 contiguous beats, B accepted on the cycle of A's last beat, no gap.
//  5. Reset mid-block: assert rst after beat 7 -> out_valid=0 next cycle; a
//     new block afterwards streams from its byte 0.
//  6. Random out_ready (50%) over 100 random blocks -> scoreboard byte order
//     matches, out_last count = 100, stall-stability assertion never fires.

Source files
------------

// File: rtl/ams_aes_pkg.sv
// Shared AES datapath constants and the unloader FSM state type.
package ams_aes_pkg;

  localparam int unsigned AES_BLK_W  = 128;
  localparam int unsigned AES_BYTE_W = 8;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } unl_state_t;

endpackage : ams_aes_pkg

// File: rtl/aes_state_unloader.sv
// Byte-serial unloader for the AES result block: takes one BLK_W block per
// handshake and streams it MSB beat first (FIPS-197 order, s[0] = data[127:120]).
// A block can be reloaded on the cycle its last beat is accepted, so
// back-to-back blocks stream with no bubble.
module aes_state_unloader
  import ams_aes_pkg::*;
#(
  parameter int unsigned BLK_W = AES_BLK_W,
  parameter int unsigned OUT_W = AES_BYTE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned NBEATS = BLK_W / OUT_W;
  localparam int unsigned CNT_W  = $clog2(NBEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

  unl_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] sreg_q, sreg_d;
  logic             load;

  // Outputs come straight from flops, so they only move on an accepted beat.
  assign out_valid = (state_q == ST_STREAM);
  assign busy      = (state_q == ST_STREAM);
  assign out_data  = sreg_q[BLK_W-1 -: OUT_W];
  assign out_last  = (state_q == ST_STREAM) && (cnt_q == LAST_CNT);

  // Combinational from out_ready so the next block loads under the last beat.
  assign in_ready = !rst && ((state_q == ST_IDLE) || (out_ready && out_last));
  assign load     = in_valid && in_ready;

  // Next-state for FSM, beat counter and shift register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          sreg_d  = in_data;
          cnt_d   = '0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (out_ready) begin
          if (!out_last) begin
            // Zeros fill the vacated low beat.
            sreg_d = {sreg_q[BLK_W-OUT_W-1:0], {OUT_W{1'b0}}};
            cnt_d  = cnt_q + CNT_W'(1);
          end else if (load) begin
            sreg_d = in_data;
            cnt_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any partially streamed block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
    end
  end

endmodule : aes_state_unloader

// File: tb/tb_aes_state_unloader.sv
// Self-checking bench for aes_state_unloader: cycle table for reset and a
// single block, then hand sequences for stall, back-to-back, mid-block reset
// and random backpressure, with a scoreboard monitor for byte order.
module tb_aes_state_unloader;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         out_last;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  aes_state_unloader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [127:0] ramp(input logic [7:0] base);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = base + 8'(i);
    return r;
  endfunction

  function automatic logic [127:0] fill(input logic [7:0] b);
    return {16{b}};
  endfunction

  // ---------------- scoreboard monitor ----------------
  bit         mon_en = 1'b0;
  logic [7:0] exp_q[$];
  int         beat_idx = 0;
  int         n_last = 0;
  int         n_beats = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  // Samples 2 time units after the falling edge, once inputs have settled.
  always @(negedge clk) begin
    #2;
    if (rst || !mon_en) begin
      exp_q.delete();
      beat_idx   = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall out_valid", out_valid, 1'b1);
        chk("stall out_data", out_data, prev_data);
        chk("stall out_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        n_beats++;
        if (out_last) n_last++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL beat order: got beat %0h, expected no beat (t=%0t)", out_data, $time);
        end else begin
          chk("beat data", out_data, exp_q.pop_front());
          chk("beat last", out_last, beat_idx == 15);
          beat_idx = (beat_idx + 1) % 16;
        end
      end
      if (in_valid && in_ready)
        for (int i = 0; i < 16; i++) exp_q.push_back(in_data[127-8*i -: 8]);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Waits for the block to finish; an expired budget counts as a failure.
  task automatic drain(input int budget);
    int t;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    t = 0;
    while (busy && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("drain busy", busy, 1'b0);
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_data;
    logic         e_in_ready;
    logic         e_out_valid;
    logic         e_out_last;
    logic         e_busy;
    logic         chk_data;
    logic [7:0]   e_out_data;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_t v;
    int   l0, b0, c;
    logic got;

    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = ramp(8'h00);
    out_ready = 1'b1;

    // Reset held 3 cycles with in_valid high.
    for (int i = 0; i < 3; i++) begin
      v = '{rst: 1, in_valid: 1, out_ready: 1, in_data: ramp(8'h00), e_in_ready: 0,
            e_out_valid: 0, e_out_last: 0, e_busy: 0, chk_data: 1, e_out_data: 8'h00};
      vecs.push_back(v);
    end
    // Accept block 00..0F from IDLE.
    v = '{rst: 0, in_valid: 1, out_ready: 1, in_data: ramp(8'h00), e_in_ready: 1,
          e_out_valid: 0, e_out_last: 0, e_busy: 0, chk_data: 1, e_out_data: 8'h00};
    vecs.push_back(v);
    // 16 beats on consecutive cycles.
    for (int k = 0; k < 16; k++) begin
      v = '{rst: 0, in_valid: 0, out_ready: 1, in_data: '0, e_in_ready: (k == 15),
            e_out_valid: 1, e_out_last: (k == 15), e_busy: 1, chk_data: 1,
            e_out_data: 8'(k)};
      vecs.push_back(v);
    end
    // Back to IDLE.
    v = '{rst: 0, in_valid: 0, out_ready: 1, in_data: '0, e_in_ready: 1,
          e_out_valid: 0, e_out_last: 0, e_busy: 0, chk_data: 0, e_out_data: 8'h00};
    vecs.push_back(v);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      in_valid  = vecs[i].in_valid;
      out_ready = vecs[i].out_ready;
      in_data   = vecs[i].in_data;
      #1;
      chk($sformatf("v%0d in_ready", i), in_ready, vecs[i].e_in_ready);
      chk($sformatf("v%0d out_valid", i), out_valid, vecs[i].e_out_valid);
      chk($sformatf("v%0d out_last", i), out_last, vecs[i].e_out_last);
      chk($sformatf("v%0d busy", i), busy, vecs[i].e_busy);
      if (vecs[i].chk_data) chk($sformatf("v%0d out_data", i), out_data, vecs[i].e_out_data);
    end

    mon_en = 1'b1;

    // ---- Backpressure on beats 3 and 4 ----
    l0 = n_last;
    b0 = n_beats;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = ramp(8'h00);
    out_ready = 1'b1;
    #1;
    chk("bp accept", in_ready, 1'b1);
    for (int cy = 0; cy <= 26; cy++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = !((cy >= 3 && cy <= 7) || (cy >= 9 && cy <= 13));
      #1;
      if (cy == 5)  chk("bp hold 03", out_data, 8'h03);
      if (cy == 11) chk("bp hold 04", out_data, 8'h04);
      if (cy == 14) chk("bp beat4 out", out_data, 8'h04);
      if (cy == 25) chk("bp last", out_last, 1'b1);
      if (cy == 26) chk("bp idle", out_valid, 1'b0);
    end
    chk("bp beat count", n_beats - b0, 16);
    chk("bp last count", n_last - l0, 1);

    // ---- Back-to-back AA.. then BB.. ----
    b0 = n_beats;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = fill(8'hAA);
    out_ready = 1'b1;
    #1;
    chk("b2b accept A", in_ready, 1'b1);
    for (int cy = 0; cy < 32; cy++) begin
      @(negedge clk);
      if (cy == 0) in_data = fill(8'hBB);
      if (cy == 16) in_valid = 1'b0;
      #1;
      chk($sformatf("b2b valid c%0d", cy), out_valid, 1'b1);
      if (cy == 15) begin
        chk("b2b A last", out_last, 1'b1);
        chk("b2b B accept", in_ready, 1'b1);
      end
      if (cy == 16) chk("b2b B byte0", out_data, 8'hBB);
    end
    @(negedge clk);
    #1;
    chk("b2b idle", out_valid, 1'b0);
    chk("b2b beat count", n_beats - b0, 32);

    // ---- Reset mid-block ----
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = ramp(8'h10);
    #1;
    for (int cy = 0; cy < 8; cy++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
    end
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = ramp(8'h40);
    #1;
    chk("mid beat8 data", out_data, 8'h18);
    chk("mid rst in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid out_valid", out_valid, 1'b0);
    chk("mid busy", busy, 1'b0);
    chk("mid in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = ramp(8'h20);
    #1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("mid new byte0", out_data, 8'h20);
    chk("mid new valid", out_valid, 1'b1);
    drain(40);

    // ---- Random backpressure, 100 blocks ----
    l0 = n_last;
    for (int b = 0; b < 100; b++) begin
      got = 1'b0;
      c   = 0;
      while (!got && c < 400) begin
        @(negedge clk);
        if (c == 0) begin
          in_valid = 1'b1;
          in_data  = {$urandom, $urandom, $urandom, $urandom};
        end
        out_ready = 1'($urandom_range(0, 1));
        #1;
        got = in_ready;
        c++;
      end
      if (!got) begin
        n_chk++;
        $display("FAIL rand accept: block %0d not accepted, expected accept within 400 cycles", b);
      end
    end
    @(negedge clk);
    drain(400);
    chk("rand last count", n_last - l0, 100);
    chk("rand sb empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_aes_state_unloader
